if_fetch_unit: RTL

Instruction-fetch stage that sits directly downstream of pc_gen in mini_cpu.
- Takes the current PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Returns the sequential successor PC to pc_gen as its pre_pc.
- Loads the fetched instruction into the IF/ID pipeline register.
- Absorbs IF/ID stalls with a one-entry hold buffer and discards in-flight fetches on a taken-branch/jump flush.

---
 rtl/if_fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID register with a
// one-entry hold buffer for stalls, and drop-on-flush for redirected fetches.
module if_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic [31:0] pre_pc_o,
  output logic        fetch_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        if_id_stall_i,
  input  logic        if_id_flush_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_next_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_misalign_o
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] req_pc;
  logic        req_mis;
  logic [31:0] hold_data;
  logic        hold_vld;
  logic        deliver_resp, deliver_hold, deliver;
  logic [31:0] deliver_data;

  assign pre_pc_o    = pc_i + PC_STEP;
  assign imem_req_o  = (state == S_REQ) && !reset;
  assign imem_addr_o = {pc_i[31:2], 2'b00};

  // Flush outranks both delivery paths so a redirect never lets a stale instruction through.
  assign deliver_resp  = (state == S_RESP) && imem_rvalid_i && !if_id_stall_i && !if_id_flush_i;
  assign deliver_hold  = (state == S_HOLD) && hold_vld && !if_id_stall_i && !if_id_flush_i;
  assign deliver       = deliver_resp || deliver_hold;
  assign deliver_data  = deliver_hold ? hold_data : imem_rdata_i;
  assign fetch_stall_o = !(deliver || if_id_flush_i);

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (imem_gnt_i) state_nxt = if_id_flush_i ? S_DROP : S_RESP;
      S_RESP: begin
        if (imem_rvalid_i) begin
          if (if_id_flush_i || !if_id_stall_i) state_nxt = S_REQ;
          else                                 state_nxt = S_HOLD;
        end else if (if_id_flush_i) begin
          state_nxt = S_DROP;
        end
      end
      S_HOLD: if (if_id_flush_i || !if_id_stall_i) state_nxt = S_REQ;
      S_DROP: if (imem_rvalid_i) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_REQ;
      req_pc    <= '0;
      req_mis   <= 1'b0;
      hold_data <= '0;
      hold_vld  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ && imem_gnt_i) begin
        req_pc  <= pc_i;
        req_mis <= |pc_i[1:0];
      end
      if (state == S_RESP && imem_rvalid_i && if_id_stall_i && !if_id_flush_i) begin
        hold_data <= imem_rdata_i;
        hold_vld  <= 1'b1;
      end else if (state == S_HOLD && (deliver_hold || if_id_flush_i)) begin
        hold_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_valid_o    <= 1'b0;
      if_id_pc_o       <= '0;
      if_id_pc_next_o  <= '0;
      if_id_instr_o    <= NOP_INSTR;
      if_id_misalign_o <= 1'b0;
    end else if (if_id_flush_i) begin
      if_id_valid_o    <= 1'b0;
      if_id_instr_o    <= NOP_INSTR;
      if_id_misalign_o <= 1'b0;
    end else if (deliver) begin
      if_id_valid_o    <= 1'b1;
      if_id_pc_o       <= req_pc;
      if_id_pc_next_o  <= req_pc + PC_STEP;
      if_id_instr_o    <= deliver_data;
      if_id_misalign_o <= req_mis;
    end
  end

endmodule
